// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// Latency: operand accepted at edge k, result valid after edge k+BINLEN.
// Backpressure: result held in DONE until out_ready; no new operand accepted meanwhile.
//
// Ports:
//   clk, rst              - clock, async active-high reset
//   BIN, in_valid/ready   - operand input handshake (in_ready high only in IDLE)
//   BCD, ovf              - packed BCD result (digit 0 in bits [3:0]) and overflow flag
//   out_valid/out_ready   - result output handshake (out_valid high only in DONE)
module bin2bcd_seq #(
  parameter int DECLEN = 9,
  parameter int BINLEN = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BINLEN-1:0]     BIN,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DECLEN*4-1:0]   BCD,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CW = $clog2(BINLEN + 1);
  localparam int BW = DECLEN * 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [BINLEN-1:0] r_shift;
  logic [BW-1:0]     r_work;
  logic              r_sticky;
  logic [BW-1:0]     r_bcd;
  logic              r_ovf;

  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_next_work;
  logic              w_carry;
  logic              w_last;

  // One double-dabble step: correct every digit >= 5, then shift the
  // binary MSB in at BCD bit 0. The bit leaving the top digit is a
  // multiple of 10^DECLEN, so dropping it keeps the work value exact mod
  // 10^DECLEN while it feeds the sticky overflow flag.
  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < DECLEN; i++) begin
      if (r_work[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_work[i*4 +: 4] + 4'd3;
      end
    end
    w_next_work = {w_adj[BW-2:0], r_shift[BINLEN-1]};
    w_carry     = w_adj[BW-1];
    w_last      = (r_cnt == CW'(BINLEN - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_work   <= '0;
      r_sticky <= 1'b0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift  <= BIN;
            r_work   <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          r_work   <= w_next_work;
          r_shift  <= {r_shift[BINLEN-2:0], 1'b0};
          r_sticky <= r_sticky | w_carry;
          if (w_last) begin
            // Published result includes this final step's shifted-out bit.
            r_bcd   <= w_next_work;
            r_ovf   <= r_sticky | w_carry;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs are pure state decodes, independent of the
  // partner's valid/ready inputs.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign BCD       = r_bcd;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // default instance: 9 digits, 30-bit input
  logic [29:0] bin;
  logic        in_valid, in_ready, ovf, out_valid, out_ready;
  logic [35:0] bcd;
  // small instance: 3 digits, 10-bit input
  logic [9:0]  s_bin;
  logic        s_in_valid, s_in_ready, s_ovf, s_out_valid, s_out_ready;
  logic [11:0] s_bcd;

  bin2bcd_seq dut (
    .clk(clk), .rst(rst), .BIN(bin), .in_valid(in_valid), .in_ready(in_ready),
    .BCD(bcd), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  bin2bcd_seq #(.DECLEN(3), .BINLEN(10)) dut_s (
    .clk(clk), .rst(rst), .BIN(s_bin), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .BCD(s_bcd), .ovf(s_ovf), .out_valid(s_out_valid), .out_ready(s_out_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits of v by plain division, truncated to nd digits.
  function automatic logic [63:0] model_bcd(input longint v, input int nd);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // BCD back to binary; flags any digit above 9.
  task automatic bcd_to_bin(input logic [63:0] x, input int nd, output longint v, output logic bad);
    v = 0;
    bad = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      if (x[i*4 +: 4] > 4'd9) bad = 1'b1;
      v = v * 10 + longint'(x[i*4 +: 4]);
    end
  endtask

  // Full transaction on the default instance; call and return at a negedge.
  task automatic run_big(input logic [29:0] b, output logic [35:0] r, output logic ov, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    bin = b; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; bin = '0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    r = bcd; ov = ovf;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_small(input logic [9:0] b, output logic [11:0] r, output logic ov, output int lat);
    int n;
    n = 0;
    while (!s_in_ready && n < 100) begin @(negedge clk); n++; end
    s_bin = b; s_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    s_in_valid = 1'b0; s_bin = '0;
    lat = 0;
    while (!s_out_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    r = s_bcd; ov = s_ovf;
    s_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  typedef struct {
    logic [29:0] bin;
    logic [35:0] bcd;
    logic        ovf;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [35:0] r;
    logic [11:0] sr;
    logic [63:0] m;
    logic        ov, bad;
    int          lat, n, seen;
    longint      v;
    logic [29:0] b;

    vecs[0] = '{30'd0,          36'h000000000, 1'b0};
    vecs[1] = '{30'd999999999,  36'h999999999, 1'b0};
    vecs[2] = '{30'd1000000000, 36'h000000000, 1'b1};
    vecs[3] = '{30'h3FFFFFFF,   36'h073741823, 1'b1};
    vecs[4] = '{30'd1,          36'h000000001, 1'b0};
    vecs[5] = '{30'd500000005,  36'h500000005, 1'b0};

    rst = 1'b1;
    bin = '0; in_valid = 1'b0; out_ready = 1'b0;
    s_bin = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_bcd", bcd, 0);
    check("reset_ovf", ovf, 0);
    check("reset_small_in_ready", s_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    // directed vectors
    for (int i = 0; i < 6; i++) begin
      run_big(vecs[i].bin, r, ov, lat);
      check($sformatf("vec%0d_bcd", i), r, vecs[i].bcd);
      check($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
      check($sformatf("vec%0d_latency", i), lat, 30);
    end

    // result held with out_ready low; input activity ignored
    bin = 30'd100; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    check("hold_latency", n, 30);
    for (int i = 0; i < 5; i++) begin
      bin = 30'($urandom); in_valid = (i % 2 == 0);
      @(posedge clk); @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_bcd", bcd, 36'h000000100);
      check("hold_ovf", ovf, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    check("release_bcd_kept", bcd, 36'h000000100);

    // previous result stays visible during the next conversion
    bin = 30'd777; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("midconv_bcd_kept", bcd, 36'h000000100);
    check("midconv_out_valid", out_valid, 0);
    n = 15;
    while (!out_valid && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    check("second_latency", n, 30);
    check("second_bcd", bcd, 36'h000000777);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;

    // leave ovf=1 and nonzero BCD so the reset clearing is observable
    run_big(30'd1000000005, r, ov, lat);
    check("pre_rst_bcd", r, 36'h000000005);
    check("pre_rst_ovf", ov, 1);

    // async reset at conversion step 12
    bin = 30'd5; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bcd", bcd, 0);
    check("async_rst_ovf", ovf, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("aborted_no_result", seen, 0);
    run_big(30'd12345, r, ov, lat);
    check("post_rst_bcd", r, 36'h000012345);
    check("post_rst_ovf", ov, 0);
    check("post_rst_latency", lat, 30);

    // random in-range operands, back-to-back, recovered through BCD->binary
    for (int i = 0; i < 1000; i++) begin
      b = 30'($urandom_range(0, 999999999));
      run_big(b, r, ov, lat);
      bcd_to_bin({28'd0, r}, 9, v, bad);
      check("rand_recovered", v, longint'(b));
      check("rand_digit_le9", bad, 0);
      check("rand_ovf", ov, 0);
      check("rand_latency", lat, 30);
    end

    // random full-range operands against the modulo model
    for (int i = 0; i < 100; i++) begin
      b = 30'($urandom);
      run_big(b, r, ov, lat);
      m = model_bcd(longint'(b), 9);
      check("full_bcd", r, m);
      check("full_ovf", ov, (longint'(b) >= pow10(9)));
    end

    // small instance: every input
    for (int i = 0; i < 1024; i++) begin
      run_small(10'(i), sr, ov, lat);
      m = model_bcd(longint'(i), 3);
      check("small_bcd", sr, m);
      check("small_ovf", ov, (i >= 1000));
      if (i == 0) check("small_latency", lat, 10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
